// File: rtl/elc3_control.sv
// LC-3 style multi-cycle control unit: Moore FSM decoding datapath controls
// from state, with a single Mealy term (LD_MDR on memory-ready during reads).
module elc3_control (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic        i_continue,
  input  logic [15:0] i_ir,
  input  logic        i_ben,
  input  logic        i_r,
  output logic        o_ld_mar,
  output logic        o_ld_mdr,
  output logic        o_ld_ir,
  output logic        o_ld_ben,
  output logic        o_ld_reg,
  output logic        o_ld_cc,
  output logic        o_ld_pc,
  output logic        o_gate_pc,
  output logic        o_gate_mdr,
  output logic        o_gate_alu,
  output logic        o_gate_marmux,
  output logic        o_addr1mux,
  output logic [1:0]  o_addr2mux,
  output logic [1:0]  o_pcmux,
  output logic [1:0]  o_drmux,
  output logic [1:0]  o_sr1mux,
  output logic [1:0]  o_marmux,
  output logic [1:0]  o_aluk,
  output logic        o_mio_en,
  output logic        o_r_w
);

  typedef enum logic [4:0] {
    StHalted, St18, St33, St35, St32, St1, St5, St9, St0, St22, St12, St4, St21,
    St20, St2, St3, St6, St7, St25, St27, St14, St23, St16, StPause, StPauseHi
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // State register; reset parks the machine in HALTED immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StHalted;
    else       r_state <= w_state_next;
  end

  // Next-state and output decode; every output defaults to 0.
  always_comb begin
    w_state_next  = r_state;
    o_ld_mar      = 1'b0;
    o_ld_mdr      = 1'b0;
    o_ld_ir       = 1'b0;
    o_ld_ben      = 1'b0;
    o_ld_reg      = 1'b0;
    o_ld_cc       = 1'b0;
    o_ld_pc       = 1'b0;
    o_gate_pc     = 1'b0;
    o_gate_mdr    = 1'b0;
    o_gate_alu    = 1'b0;
    o_gate_marmux = 1'b0;
    o_addr1mux    = 1'b0;
    o_addr2mux    = 2'b00;
    o_pcmux       = 2'b00;
    o_drmux       = 2'b00;
    o_sr1mux      = 2'b00;
    o_marmux      = 2'b00;
    o_aluk        = 2'b00;
    o_mio_en      = 1'b0;
    o_r_w         = 1'b0;
    unique case (r_state)
      StHalted: if (i_run) w_state_next = St18;
      St18: begin
        o_gate_pc    = 1'b1;
        o_ld_mar     = 1'b1;
        o_ld_pc      = 1'b1;
        w_state_next = St33;
      end
      St33, St25: begin
        o_mio_en = 1'b1;
        // MDR captures read data only in the cycle memory reports ready.
        o_ld_mdr = i_r;
        if (i_r) w_state_next = (r_state == St33) ? St35 : St27;
      end
      St35: begin
        o_gate_mdr   = 1'b1;
        o_ld_ir      = 1'b1;
        w_state_next = St32;
      end
      St32: begin
        o_ld_ben = 1'b1;
        case (i_ir[15:12])
          4'b0001: w_state_next = St1;
          4'b0101: w_state_next = St5;
          4'b1001: w_state_next = St9;
          4'b0000: w_state_next = St0;
          4'b1100: w_state_next = St12;
          4'b0100: w_state_next = St4;
          4'b0010: w_state_next = St2;
          4'b0110: w_state_next = St6;
          4'b1110: w_state_next = St14;
          4'b0011: w_state_next = St3;
          4'b0111: w_state_next = St7;
          4'b1101: w_state_next = StPause;
          default: w_state_next = St18;  // unused opcodes act as NOP
        endcase
      end
      St1, St5, St9: begin
        o_sr1mux     = 2'b01;
        o_aluk       = (r_state == St1) ? 2'b00 : (r_state == St5) ? 2'b01 : 2'b10;
        o_gate_alu   = 1'b1;
        o_ld_reg     = 1'b1;
        o_ld_cc      = 1'b1;
        w_state_next = St18;
      end
      St0: w_state_next = i_ben ? St22 : St18;
      St22: begin
        o_addr2mux   = 2'b10;
        o_pcmux      = 2'b10;
        o_ld_pc      = 1'b1;
        w_state_next = St18;
      end
      St12, St20: begin
        o_sr1mux     = 2'b01;
        o_addr1mux   = 1'b1;
        o_pcmux      = 2'b10;
        o_ld_pc      = 1'b1;
        w_state_next = St18;
      end
      St4: begin
        o_gate_pc    = 1'b1;
        o_drmux      = 2'b01;
        o_ld_reg     = 1'b1;
        w_state_next = i_ir[11] ? St21 : St20;
      end
      St21: begin
        o_addr2mux   = 2'b11;
        o_pcmux      = 2'b10;
        o_ld_pc      = 1'b1;
        w_state_next = St18;
      end
      St2, St3: begin
        o_addr2mux    = 2'b10;
        o_gate_marmux = 1'b1;
        o_ld_mar      = 1'b1;
        w_state_next  = (r_state == St2) ? St25 : St23;
      end
      St6, St7: begin
        o_sr1mux      = 2'b01;
        o_addr1mux    = 1'b1;
        o_addr2mux    = 2'b01;
        o_gate_marmux = 1'b1;
        o_ld_mar      = 1'b1;
        w_state_next  = (r_state == St6) ? St25 : St23;
      end
      St27: begin
        o_gate_mdr   = 1'b1;
        o_ld_reg     = 1'b1;
        o_ld_cc      = 1'b1;
        w_state_next = St18;
      end
      St14: begin
        o_addr2mux    = 2'b10;
        o_gate_marmux = 1'b1;
        o_ld_reg      = 1'b1;
        o_ld_cc       = 1'b1;
        w_state_next  = St18;
      end
      St23: begin
        o_aluk       = 2'b11;
        o_gate_alu   = 1'b1;
        o_ld_mdr     = 1'b1;
        w_state_next = St16;
      end
      St16: begin
        o_mio_en = 1'b1;
        o_r_w    = 1'b1;
        if (i_r) w_state_next = St18;
      end
      StPause:   if (i_continue)  w_state_next = StPauseHi;
      StPauseHi: if (!i_continue) w_state_next = St18;
      default:   w_state_next = StHalted;
    endcase
  end

endmodule

// File: doc/elc3_control.md
ELC3_CONTROL -- requirements
Module: elc3_control

Interface
REQ-001 Clk  in  1  sole clock; all state changes on rising edge.
REQ-002 Reset  in  1  asynchronous, active-high; forces state HALTED immediately.
REQ-003 Run  in  1  level; leaves HALTED and starts fetch.
REQ-004 Continue  in  1  level; releases PAUSE.
REQ-005 IR  in  16  current instruction register contents.
REQ-006 BEN  in  1  branch enable, registered by the datapath on LD_BEN.
REQ-007 R  in  1  memory ready; 1 = current memory access completes this cycle.
REQ-008 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC  out  1 each  datapath register loads.
REQ-009 GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle.
REQ-010 ADDR1MUX  out  1: 0=PC, 1=SR1.
REQ-011 ADDR2MUX  out  2: 00=0, 01=SEXT(IR[5:0]), 10=SEXT(IR[8:0]), 11=SEXT(IR[10:0]).
REQ-012 PCMUX  out  2: 00=PC+1, 01=Bus, 10=adder.
REQ-013 DRMUX  out  2: 00=IR[11:9], 01=R7. SR1MUX  out  2: 00=IR[11:9], 01=IR[8:6].
REQ-014 MARMUX  out  2: 00=adder. ALUK  out  2: 00=ADD, 01=AND, 10=NOT, 11=PASSA.
REQ-015 MIO_EN, R_W  out  1 each  memory enable; R_W 1=write, 0=read.

Function
REQ-016 Moore FSM; every output is a pure decode of state (IR/R/BEN used only for transitions, except REQ-020); unlisted outputs are 0 in every state.
REQ-017 HALTED: all outputs 0; Run=1 -> S18, else hold.
REQ-018 S18: GatePC, LD_MAR, PCMUX=00, LD_PC -> S33.
REQ-019 S33: MIO_EN=1, R_W=0; hold while R=0; R=1 -> S35.
REQ-020 LD_MDR in S33/S25 asserted only in the cycle R=1 (the sole Mealy exception).
REQ-021 S35: GateMDR, LD_IR -> S32.
REQ-022 S32: LD_BEN; next state by IR[15:12]: 0001->S1, 0101->S5, 1001->S9, 0000->S0, 1100->S12, 0100->S4, 0010->S2, 0110->S6, 1110->S14, 0011->S3, 0111->S7, 1101->PAUSE; 1000,1010,1011,1111 -> S18 (NOP).
REQ-023 S1/S5/S9: SR1MUX=01, ALUK=00/01/10, GateALU, DRMUX=00, LD_REG, LD_CC -> S18.
REQ-024 S0: BEN=1 -> S22, else S18. S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S18.
REQ-025 S12: SR1MUX=01, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> S18.
REQ-026 S4: GatePC, DRMUX=01, LD_REG -> S21 if IR[11]=1, else S20.
REQ-027 S21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC -> S18. S20: as S12 -> S18.
REQ-028 S2/S3: ADDR1MUX=0, ADDR2MUX=10, MARMUX=00, GateMARMUX, LD_MAR -> S25/S23.
REQ-029 S6/S7: SR1MUX=01, ADDR1MUX=1, ADDR2MUX=01, MARMUX=00, GateMARMUX, LD_MAR -> S25/S23.
REQ-030 S25: as S33; R=1 -> S27. S27: GateMDR, DRMUX=00, LD_REG, LD_CC -> S18.
REQ-031 S14: ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, DRMUX=00, LD_REG, LD_CC -> S18.
REQ-032 S23: SR1MUX=00, ALUK=11, GateALU, LD_MDR -> S16.
REQ-033 S16: MIO_EN=1, R_W=1; hold while R=0; R=1 -> S18.
REQ-034 PAUSE: outputs 0; waits Continue=1 (PAUSE_HI), then Continue=0 -> S18.
REQ-035 Run ignored outside HALTED; R ignored outside S33/S25/S16; no timeout on R.
REQ-036 Instruction latency with R=1 at first sample: fetch+decode 4 cycles; ADD total 5; LD total 7; ST total 7.

Reset
REQ-037 Reset=1 asynchronously forces HALTED and all outputs to 0 within the same cycle, from any state including mid memory access; held until Reset=0 and Run=1.
REQ-038 No cycle-level state survives reset; first post-reset action is S18.

Verification
REQ-039 Reset, Run=1, R=1, IR=0x1042 (ADD) -> states 18,33,35,32,1; LD_REG+LD_CC one cycle in S1, SR1MUX=01.
REQ-040 IR=0x0402, BEN=0 -> S0 then S18, LD_PC never high in S0; BEN=1 -> S22 with PCMUX=10, LD_PC=1.
REQ-041 S33 with R=0 for 3 cycles then 1 -> MIO_EN high 4 cycles, LD_MDR only in 4th, then S35.
REQ-042 IR=0x3005 (ST), R=1 -> 18,33,35,32,3,23,16; S16 MIO_EN=1, R_W=1.
REQ-043 Reset asserted mid-S25 -> outputs 0 immediately, HALTED; Run=1 after release -> S18.
REQ-044 IR=0xD000 -> PAUSE; Continue 0->1->0 -> S18; IR=0xF025 -> S18 directly after S32.
